key_event_sched: RTL and testbench
==================================

# key_event_sched

Per-button event scheduler behind the vector debouncer. It generates the debouncer's `tick_en` sampling strobe and watches the debounced button levels. It runs a press/hold/repeat state machine per channel and arbitrates the resulting events round-robin onto a single valid/ready event stream consumed by the UI/control logic.

## Interface

Parameters:
- `WIDTH`, 4: number of button channels (1..16).
- `IDW`, 2: event id width; `2**IDW >= WIDTH`.
- `TICK_DIV`, 50000: clk cycles per `tick_en` pulse (≥2).
- `HOLD_TICKS`, 500: ticks a press must persist before a HOLD event (1..65535).
- `REPEAT_TICKS`, 100: ticks between REPEAT events after HOLD (1..65535).

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `tick_en` out 1: one-cycle sampling strobe; drives the debouncer.
- `btn_db` in WIDTH: debounced button levels, 1 = pressed.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event when high with `evt_valid`.
- `evt_id` out IDW: channel index of the event.
- `evt_type` out 2: 00 PRESS, 01 RELEASE, 10 HOLD, 11 REPEAT.
- `evt_ovf` out WIDTH: sticky per-channel lost-event flag.

## Operation

Prescaler:
- Counter runs 0..TICK_DIV-1.
- `tick_en`=1 in the cycle the count equals TICK_DIV-1; the counter then wraps to 0.

Edge detect:
- `prev` register samples `btn_db` every clk.
- rise = `btn_db & ~prev`; fall = `~btn_db & prev`.

Per-channel FSM (16-bit tick counter `cnt`):
- IDLE: on rise, post PRESS, `cnt`←0, go to PRESSED.
- PRESSED: on fall, post RELEASE, go to IDLE. Otherwise, on `tick_en`, `cnt`++; when the incremented value equals HOLD_TICKS, post HOLD, `cnt`←0, go to REPEAT.
- REPEAT: on fall, post RELEASE, go to IDLE. Otherwise, on `tick_en`, `cnt`++; when it equals REPEAT_TICKS, post REPEAT, `cnt`←0.
- Fall and threshold in the same cycle: only RELEASE is posted.

Pending slots:
- Each channel has one pending slot: valid bit plus type.
- "Post" writes the slot.
- Posting into a slot that is already valid and not granted this cycle overwrites the type and sets `evt_ovf[i]`.
- Posting in the cycle the slot is granted stores the new event with no overflow.
- `evt_ovf` clears only on `rst`.

Arbiter / output register:
- A grant occurs when (`!evt_valid || evt_ready`) and any slot is valid.
- Search starts at the channel after the last granted index and wraps; the last granted index resets to WIDTH-1, so channel 0 has first priority.
- On grant: the granted slot clears; `evt_id`/`evt_type` load and `evt_valid`←1 on the next edge.
- If (`!evt_valid || evt_ready`) and no slot is valid: `evt_valid`←0.
- While `evt_valid && !evt_ready`, `evt_id`/`evt_type` hold stable.

## Timing

Reset values:
- prescaler 0, `tick_en` 0, `prev` 0, all FSMs IDLE, `cnt` 0, slots empty.
- `evt_valid` 0, `evt_id` 0, `evt_type` 00, `evt_ovf` 0, last-grant WIDTH-1.

Tick and event latency:
- First `tick_en` occurs TICK_DIV cycles after `rst` deasserts (cycles are counted from the first non-reset edge, which is cycle 1). It then repeats every TICK_DIV cycles.
- Event latency: `btn_db` edge visible in cycle t → slot valid in t+1 → `evt_valid` high in t+2, provided the output is free and no other slot wins arbitration.
- Full throughput: with `evt_ready` held at 1 and slots pending, one event per cycle.

Hold and repeat timing:
- HOLD is posted on the HOLD_TICKS-th `tick_en` after the press cycle.
- Each REPEAT is posted every REPEAT_TICKS ticks after that.

Reset behaviour:
- Reset mid-operation drops pending and presented events immediately.
- A button held through reset yields PRESS with `evt_valid` at cycle 2 after reset release.

## Configuration

- `KEY_AUTOREPEAT_EN` defined: the REPEAT state emits periodic REPEAT events as described above.
- `KEY_AUTOREPEAT_EN` undefined:
  - After HOLD the channel sits in REPEAT with `cnt` frozen until release.
  - No REPEAT events are ever produced.
  - The REPEAT_TICKS comparator is not built.

## Test plan

- Reset then free run, TICK_DIV=4: `tick_en` pulses at cycles 4, 8, 12; `evt_valid` stays 0.
- Ch1 rises at cycle t with `evt_ready`=1: `evt_valid`=1, `evt_id`=1, `evt_type`=00 at t+2. Fall later → RELEASE (01) two cycles after the fall.
- HOLD_TICKS=3, REPEAT_TICKS=2, ch0 held for 9 ticks: PRESS, then HOLD at tick 3, REPEAT at ticks 5, 7, 9, then RELEASE. With the macro undefined: PRESS, HOLD, RELEASE only.
- Ch0, ch2 and ch3 rise in the same cycle with `evt_ready`=1: ids 0, 2, 3 on consecutive cycles. A second simultaneous burst starts at id 0 again, since the search restarts after last grant 3.
- `evt_ready`=0 with ch1 PRESS presented, then ch1 releases and re-presses: one overwrite per new event, `evt_ovf[1]`=1, output held stable. Raising `evt_ready` then delivers the PRESS, followed by the latest type.
- `rst` asserted while `evt_valid`=1 and slots pending: next cycle `evt_valid`=0, `evt_ovf`=0, no stale events after release.

Source files
------------

// File: rtl/key_event_sched.sv
// Per-button press/hold/repeat event scheduler with a round-robin valid/ready event stream.
// Optional build macro KEY_AUTOREPEAT_EN enables periodic REPEAT events after HOLD.
module key_chan #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rise,
  input  logic       fall,
  input  logic       grant,
  output logic       pend,
  output logic [1:0] ptype,
  output logic       ovf
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_REPEAT  = 2'd2;
  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_HOLD    = 2'b10;
  localparam logic [15:0] HOLD_C = 16'(HOLD_TICKS);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [1:0]  EV_REPEAT = 2'b11;
  localparam logic [15:0] RPT_C     = 16'(REPEAT_TICKS);
`endif

  logic [1:0]  state, state_n;
  logic [15:0] cnt, cnt_n, inc;
  logic        post;
  logic [1:0]  post_type;

  // A fall always wins over a tick threshold in the same cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    post      = 1'b0;
    post_type = EV_PRESS;
    inc       = cnt + 16'd1;
    case (state)
      S_IDLE: if (rise) begin
        post = 1'b1; post_type = EV_PRESS; cnt_n = '0; state_n = S_PRESSED;
      end
      S_PRESSED: if (fall) begin
        post = 1'b1; post_type = EV_RELEASE; state_n = S_IDLE;
      end else if (tick) begin
        if (inc == HOLD_C) begin
          post = 1'b1; post_type = EV_HOLD; cnt_n = '0; state_n = S_REPEAT;
        end else cnt_n = inc;
      end
      S_REPEAT: if (fall) begin
        post = 1'b1; post_type = EV_RELEASE; state_n = S_IDLE;
      end
`ifdef KEY_AUTOREPEAT_EN
      else if (tick) begin
        if (inc == RPT_C) begin
          post = 1'b1; post_type = EV_REPEAT; cnt_n = '0;
        end else cnt_n = inc;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      ptype <= EV_PRESS;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (post) begin
        pend  <= 1'b1;
        ptype <= post_type;
        if (pend && !grant) ovf <= 1'b1;
      end else if (grant) pend <= 1'b0;
    end
  end
endmodule

module key_event_sched #(
  parameter int WIDTH        = 4,
  parameter int IDW          = 2,
  parameter int TICK_DIV     = 50000,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick_en,
  input  logic [WIDTH-1:0] btn_db,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [1:0]       evt_type,
  output logic [WIDTH-1:0] evt_ovf
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  if (WIDTH < 1 || WIDTH > 16 || (2**IDW) < WIDTH || TICK_DIV < 2 ||
      HOLD_TICKS < 1 || HOLD_TICKS > 65535 ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_cfg
    $error("key_event_sched: parameter out of range");
  end

  logic [DW-1:0] div;
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      tick_en <= 1'b0;
    end else begin
      tick_en <= (div == DIV_MAX);
      div     <= (div == DIV_MAX) ? '0 : div + 1'b1;
    end
  end

  logic [WIDTH-1:0] prev, rise, fall;
  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= btn_db;
  end
  assign rise = btn_db & ~prev;
  assign fall = ~btn_db & prev;

  logic [WIDTH-1:0]      pend, grant;
  logic [WIDTH-1:0][1:0] ptype;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    key_chan #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_chan (
      .clk(clk), .rst(rst), .tick(tick_en),
      .rise(rise[g]), .fall(fall[g]), .grant(grant[g]),
      .pend(pend[g]), .ptype(ptype[g]), .ovf(evt_ovf[g])
    );
  end

  logic [IDW-1:0] last, gidx;
  logic [1:0]     gtype;
  logic           found, free;

  // Two passes give round-robin order: channels above the last grant, then the rest.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gtype = 2'b00;
    for (int j = 0; j < WIDTH; j++)
      if (!found && pend[j] && j > int'(last)) begin
        found = 1'b1; gidx = IDW'(j); gtype = ptype[j];
      end
    for (int j = 0; j < WIDTH; j++)
      if (!found && pend[j] && j <= int'(last)) begin
        found = 1'b1; gidx = IDW'(j); gtype = ptype[j];
      end
  end

  assign free  = !evt_valid || evt_ready;
  assign grant = (free && found) ? (WIDTH'(1) << gidx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= 2'b00;
      last      <= IDW'(WIDTH - 1);
    end else if (free) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_id    <= gidx;
        evt_type  <= gtype;
        last      <= gidx;
      end else evt_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched: prescaler, edge events, hold/repeat, round-robin, overflow, reset.
module tb_key_event_sched;
  logic       clk = 1'b0;
  logic       rst, tick_en, evt_valid, evt_ready;
  logic [3:0] btn_db, evt_ovf;
  logic [1:0] evt_id, evt_type;

  int n_tests = 0, n_fail = 0;
  int q[$];
  int exp_ev[$];

  always #5 clk = ~clk;

  key_event_sched #(.WIDTH(4), .IDW(2), .TICK_DIV(4), .HOLD_TICKS(3), .REPEAT_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .btn_db(btn_db),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .evt_ovf(evt_ovf)
  );

  // Accepted events logged as id*4+type.
  always @(posedge clk)
    if (!rst && evt_valid && evt_ready) q.push_back(int'({evt_id, evt_type}));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic chk_evt(input string tag, input int v, input int id, input int ty);
    check({tag, "_valid"}, 32'(evt_valid), 32'(v));
    if (v != 0) begin
      check({tag, "_id"}, 32'(evt_id), 32'(id));
      check({tag, "_type"}, 32'(evt_type), 32'(ty));
    end
  endtask

  initial begin
    int ticks, guard;
    rst = 1'b1; btn_db = '0; evt_ready = 1'b1;
    cyc(3);
    check("rst_tick", 32'(tick_en), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    check("rst_type", 32'(evt_type), 0);
    check("rst_ovf", 32'(evt_ovf), 0);

    // Free run: ticks at cycles 4, 8, 12.
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("tick_c%0d", n), 32'(tick_en), 32'(n % 4 == 0));
      check($sformatf("idle_valid_c%0d", n), 32'(evt_valid), 0);
    end

    // Ch1 press and release, two-cycle latency each.
    btn_db[1] = 1'b1;
    step(); chk_evt("p1_t1", 0, 0, 0);
    step(); chk_evt("p1_t2", 1, 1, 0);
    step(); chk_evt("p1_t3", 0, 0, 0);
    step();
    btn_db[1] = 1'b0;
    step(); chk_evt("r1_t1", 0, 0, 0);
    step(); chk_evt("r1_t2", 1, 1, 1);

    // Ch0 held for 9 ticks.
    cyc(2);
    q.delete();
    btn_db[0] = 1'b1;
    ticks = 0; guard = 0;
    while (ticks < 9 && guard < 200) begin
      step(); guard++;
      if (tick_en) ticks++;
    end
    check("hold_ticks_seen", 32'(ticks), 9);
    step();
    btn_db[0] = 1'b0;
    cyc(4);
`ifdef KEY_AUTOREPEAT_EN
    exp_ev = '{0, 2, 3, 3, 3, 1};
`else
    exp_ev = '{0, 2, 1};
`endif
    check("hold_nevents", 32'(q.size()), 32'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size(); i++)
      check($sformatf("hold_ev%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp_ev[i]));

    // Simultaneous bursts after reset: 0, 2, 3 both times.
    rst = 1'b1; step(); rst = 1'b0;
    q.delete();
    btn_db = 4'b1101;
    step(); chk_evt("b1_c1", 0, 0, 0);
    step(); chk_evt("b1_c2", 1, 0, 0);
    step(); chk_evt("b1_c3", 1, 2, 0);
    step(); chk_evt("b1_c4", 1, 3, 0);
    step(); chk_evt("b1_c5", 0, 0, 0);
    btn_db = 4'b0000;
    step();
    step(); chk_evt("b2_c2", 1, 0, 1);
    step(); chk_evt("b2_c3", 1, 2, 1);
    step(); chk_evt("b2_c4", 1, 3, 1);
    step(); chk_evt("b2_c5", 0, 0, 0);

    // Backpressure with overwrite on ch1.
    evt_ready = 1'b0;
    btn_db[1] = 1'b1;
    step();
    step(); chk_evt("ov_pres", 1, 1, 0);
    check("ov_ovf_a", 32'(evt_ovf), 0);
    btn_db[1] = 1'b0;
    step(); check("ov_ovf_b", 32'(evt_ovf), 0);
    btn_db[1] = 1'b1;
    step(); check("ov_ovf_c", 32'(evt_ovf), 32'h2);
    chk_evt("ov_held1", 1, 1, 0);
    step(); chk_evt("ov_held2", 1, 1, 0);
    evt_ready = 1'b1;
    step(); chk_evt("ov_next", 1, 1, 0);
    step(); chk_evt("ov_drain", 0, 0, 0);
    check("ov_nacc", 32'(q.size()), 8);
    check("ov_acc_a", (q.size() >= 8) ? 32'(q[6]) : 32'hFFFF_FFFF, 4);
    check("ov_acc_b", (q.size() >= 8) ? 32'(q[7]) : 32'hFFFF_FFFF, 4);
    check("ov_sticky", 32'(evt_ovf), 32'h2);

    // Reset while presenting with pending slots; ch3 held through reset.
    evt_ready = 1'b0;
    btn_db = 4'b0111;
    step();
    step(); check("mr_valid_pre", 32'(evt_valid), 1);
    rst = 1'b1; btn_db = 4'b1000;
    step();
    check("mr_valid", 32'(evt_valid), 0);
    check("mr_ovf", 32'(evt_ovf), 0);
    rst = 1'b0; evt_ready = 1'b1;
    q.delete();
    step(); chk_evt("mr_c1", 0, 0, 0);
    step(); chk_evt("mr_c2", 1, 3, 0);
    step(); chk_evt("mr_c3", 0, 0, 0);
    cyc(4);
    check("mr_nacc", 32'(q.size()), 1);
    check("mr_ev0", (q.size() >= 1) ? 32'(q[0]) : 32'hFFFF_FFFF, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
